clkdiv_enable_gen: RTL and testbench



---
 rtl/clkdiv_enable_gen.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_clkdiv_enable_gen.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clkdiv_enable_gen.sv
// clkdiv_enable_gen: turns the divider's output clock into clk_src-domain
// rise/fall enables and monitors its frequency, lock and loss.
//
// Ports:
//   clk_src    source clock (also clocks the divider)
//   reset_n    asynchronous active-low reset
//   clk_div    divided clock, treated as asynchronous
//   en_rise    one clk_src cycle per clk_div rising edge
//   en_fall    one clk_src cycle per clk_div falling edge
//   meas_count rising-edge count of the last completed window
//   meas_valid one-cycle pulse when meas_count updates
//   freq_ok    last completed window within tolerance
//   lock       LOCK_WINDOWS consecutive good windows
//   clk_lost   no clk_div edge for LOST_CYCLES cycles
//   duty_err   duty imbalance flag
//
// Optional feature macro: CLKDIV_DUTY_MON_EN enables the duty monitor.
// Without it duty_err is tied low and no duty logic exists.

module clkdiv_enable_gen #(
    parameter int SYNC_STAGES   = 2,
    parameter int WINDOW_CYCLES = 125000,
    parameter int EXPECT_COUNT  = 3580,
    parameter int TOLERANCE     = 4,
    parameter int LOCK_WINDOWS  = 2,
    parameter int LOST_CYCLES   = 256,
    parameter int DUTY_TOL      = 2,
    parameter int CNT_W         = 16
) (
    input  logic             clk_src,
    input  logic             reset_n,
    input  logic             clk_div,
    output logic             en_rise,
    output logic             en_fall,
    output logic [CNT_W-1:0] meas_count,
    output logic             meas_valid,
    output logic             freq_ok,
    output logic             lock,
    output logic             clk_lost,
    output logic             duty_err
);

    localparam int WIN_W  = $clog2(WINDOW_CYCLES + 1);
    localparam int IDLE_W = $clog2(LOST_CYCLES + 1);
    localparam int GOOD_W = $clog2(LOCK_WINDOWS + 1);
    localparam int ARM_W  = $clog2(SYNC_STAGES + 2);

    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW_CYCLES);
    localparam logic [WIN_W-1:0]  WIN_ONE  = WIN_W'(1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(LOST_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_PRE = IDLE_W'(LOST_CYCLES - 1);
    localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_WINDOWS);
    localparam logic [ARM_W-1:0]  ARM_DONE = ARM_W'(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  EXP_C    = CNT_W'(EXPECT_COUNT);
    localparam logic [CNT_W-1:0]  TOL_C    = CNT_W'(TOLERANCE);

    if (SYNC_STAGES < 2 || DUTY_TOL < 0 ||
        LOCK_WINDOWS < 1 || LOST_CYCLES < 2) begin : g_param_check
        $error("clkdiv_enable_gen: illegal parameter value");
    end

    typedef enum logic {
        ST_ARM,
        ST_MEASURE
    } state_t;

    // ------------------------------------------------------------
    // Synchronizer, edge detect and arming
    // ------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic                   prev_q;
    logic [ARM_W-1:0]       arm_q;
    logic                   armed;
    logic                   rise_nx;
    logic                   fall_nx;
    logic                   edge_nx;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign armed    = (arm_q == ARM_DONE);

    // rise_nx/fall_nx are the values en_rise/en_fall take next cycle.
    // All monitor state is updated from them, so counters line up with
    // the cycle in which the enable is actually visible.
    assign rise_nx = armed & sync_out & ~prev_q;
    assign fall_nx = armed & ~sync_out & prev_q;
    assign edge_nx = rise_nx | fall_nx;

    always_ff @(posedge clk_src or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            arm_q   <= '0;
            en_rise <= 1'b0;
            en_fall <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], clk_div};
            prev_q  <= sync_out;
            if (!armed) begin
                arm_q <= arm_q + 1'b1;
            end
            en_rise <= rise_nx;
            en_fall <= fall_nx;
        end
    end

    // ------------------------------------------------------------
    // Loss watchdog
    // ------------------------------------------------------------
    logic [IDLE_W-1:0] idle_q;
    logic              lost_evt;

    // lost_evt marks the edge on which clk_lost rises; it overrides
    // every other update in the monitor.
    assign lost_evt = ~edge_nx & (idle_q == IDLE_PRE);
    assign clk_lost = (idle_q == IDLE_MAX);

    always_ff @(posedge clk_src or negedge reset_n) begin
        if (!reset_n) begin
            idle_q <= '0;
        end else if (edge_nx) begin
            idle_q <= '0;
        end else if (idle_q != IDLE_MAX) begin
            idle_q <= idle_q + 1'b1;
        end
    end

    // ------------------------------------------------------------
    // Window FSM
    // ------------------------------------------------------------
    state_t           state_q;
    state_t           state_d;
    logic [WIN_W-1:0] win_q;
    logic [WIN_W-1:0] win_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             win_end;

    always_ff @(posedge clk_src or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_ARM;
            win_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        win_end = 1'b0;
        if (lost_evt) begin
            state_d = ST_ARM;
            win_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_ARM: begin
                    if (rise_nx) begin
                        state_d = ST_MEASURE;
                        win_d   = WIN_ONE;
                        cnt_d   = CNT_ONE;
                    end
                end
                ST_MEASURE: begin
                    if (win_q == WIN_LAST) begin
                        // A rise landing on the first cycle of the
                        // new window belongs to the new window.
                        win_end = 1'b1;
                        win_d   = WIN_ONE;
                        cnt_d   = CNT_W'(rise_nx);
                    end else begin
                        win_d = win_q + 1'b1;
                        if (rise_nx && cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_ARM;
                end
            endcase
        end
    end

    // ------------------------------------------------------------
    // Window results and lock qualification
    // ------------------------------------------------------------
    logic [CNT_W-1:0]  cnt_diff;
    logic              in_tol;
    logic [GOOD_W-1:0] good_q;

    assign cnt_diff = (cnt_q >= EXP_C) ? (cnt_q - EXP_C)
                                       : (EXP_C - cnt_q);
    assign in_tol   = (cnt_diff <= TOL_C);
    assign lock     = (good_q == GOOD_MAX);

    always_ff @(posedge clk_src or negedge reset_n) begin
        if (!reset_n) begin
            meas_count <= '0;
            meas_valid <= 1'b0;
            freq_ok    <= 1'b0;
            good_q     <= '0;
        end else if (lost_evt) begin
            meas_valid <= 1'b0;
            freq_ok    <= 1'b0;
            good_q     <= '0;
        end else begin
            meas_valid <= win_end;
            if (win_end) begin
                meas_count <= cnt_q;
                freq_ok    <= in_tol;
                if (!in_tol) begin
                    good_q <= '0;
                end else if (good_q != GOOD_MAX) begin
                    good_q <= good_q + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------
    // Duty monitor
    // ------------------------------------------------------------
`ifdef CLKDIV_DUTY_MON_EN
    localparam logic [CNT_W-1:0] DTOL_C = CNT_W'(DUTY_TOL);

    logic [CNT_W-1:0] since_q;
    logic [CNT_W-1:0] high_q;
    logic [CNT_W-1:0] duty_diff;
    logic             seen_rise_q;
    logic             have_high_q;
    logic             win_bad_q;
    logic             duty_q;
    logic             bad_now;

    // since_q holds the distance in cycles between consecutive
    // enables when sampled on the next enable.
    assign duty_diff = (high_q >= since_q) ? (high_q - since_q)
                                           : (since_q - high_q);
    assign bad_now   = rise_nx & have_high_q & (duty_diff > DTOL_C);
    assign duty_err  = duty_q;

    always_ff @(posedge clk_src or negedge reset_n) begin
        if (!reset_n) begin
            since_q <= '0;
        end else if (edge_nx) begin
            since_q <= CNT_ONE;
        end else if (since_q != CNT_MAX) begin
            since_q <= since_q + 1'b1;
        end
    end

    always_ff @(posedge clk_src or negedge reset_n) begin
        if (!reset_n) begin
            high_q      <= '0;
            seen_rise_q <= 1'b0;
            have_high_q <= 1'b0;
            win_bad_q   <= 1'b0;
            duty_q      <= 1'b0;
        end else if (lost_evt) begin
            seen_rise_q <= 1'b0;
            have_high_q <= 1'b0;
            win_bad_q   <= 1'b0;
            duty_q      <= 1'b0;
        end else begin
            if (fall_nx && seen_rise_q) begin
                high_q      <= since_q;
                have_high_q <= 1'b1;
            end
            if (rise_nx) begin
                seen_rise_q <= 1'b1;
                have_high_q <= 1'b0;
            end
            // Sticky within a window; re-evaluated from that
            // window's worst period at its end.
            if (win_end) begin
                duty_q    <= win_bad_q | bad_now;
                win_bad_q <= 1'b0;
            end else if (bad_now) begin
                duty_q    <= 1'b1;
                win_bad_q <= 1'b1;
            end
        end
    end
`else
    assign duty_err = 1'b0;
`endif

endmodule

// File: tb/tb_clkdiv_enable_gen.sv
// tb_clkdiv_enable_gen: random and directed stimulus for
// clkdiv_enable_gen, checked against a cycle-indexed reference model.

module tb_clkdiv_enable_gen;

    localparam int W     = 1000;
    localparam int EXP   = 25;
    localparam int TOL   = 1;
    localparam int LOCKN = 2;
    localparam int LOST  = 256;
    localparam int DTOL  = 2;

    logic        clk_src = 1'b0;
    logic        reset_n = 1'b1;
    logic        clk_div = 1'b0;
    logic        en_rise;
    logic        en_fall;
    logic [15:0] meas_count;
    logic        meas_valid;
    logic        freq_ok;
    logic        lock;
    logic        clk_lost;
    logic        duty_err;

    always #5 clk_src = ~clk_src;

    clkdiv_enable_gen #(
        .SYNC_STAGES  (2),
        .WINDOW_CYCLES(W),
        .EXPECT_COUNT (EXP),
        .TOLERANCE    (TOL),
        .LOCK_WINDOWS (LOCKN),
        .LOST_CYCLES  (LOST),
        .DUTY_TOL     (DTOL),
        .CNT_W        (16)
    ) dut (
        .clk_src   (clk_src),
        .reset_n   (reset_n),
        .clk_div   (clk_div),
        .en_rise   (en_rise),
        .en_fall   (en_fall),
        .meas_count(meas_count),
        .meas_valid(meas_valid),
        .freq_ok   (freq_ok),
        .lock      (lock),
        .clk_lost  (clk_lost),
        .duty_err  (duty_err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // clk_div value driven after clk_src edge k, k = 0 is release
    bit hist [0:65535];
    int n;

    // reference model state
    int          m_last;
    bit          m_meas;
    int          m_start;
    int          m_cnt;
    int          m_good;
    bit          m_seen;
    bit          m_have_high;
    int          m_high;
    int          m_lastr;
    int          m_lastf;
    bit          m_winbad;
    bit          e_rise, e_fall, e_mv, e_fok, e_lock, e_lost, e_duty;
    logic [15:0] e_mc;

    // observation bookkeeping for directed checks
    int last_obs, lost_at, first_rise, first_fall, first_mv;
    int mv_seen, mv_lost, drop_seen;
    bit lost_prev, lock_prev, lost_at_fr, lock_at_drop;
    bit mv_lock [1:2];

    task automatic model_reset(input bit v0);
        n = 0;
        hist[0] = v0;
        m_last = 0; m_meas = 0; m_start = 0; m_cnt = 0; m_good = 0;
        m_seen = 0; m_have_high = 0; m_high = 0;
        m_lastr = 0; m_lastf = 0; m_winbad = 0;
        e_rise = 0; e_fall = 0; e_mv = 0; e_fok = 0;
        e_lock = 0; e_lost = 0; e_duty = 0; e_mc = '0;
    endtask

    task automatic model_step();
        bit r, f, lev, bad;
        int d;
        r = 0; f = 0; bad = 0;
        if (n >= 4) begin
            r = hist[n-3] && !hist[n-4];
            f = !hist[n-3] && hist[n-4];
        end
        e_rise = r; e_fall = f; e_mv = 0;
        if (r || f) m_last = n;
        lev    = !(r || f) && (n - m_last == LOST);
        e_lost = (n - m_last) >= LOST;
`ifdef CLKDIV_DUTY_MON_EN
        if (r && m_have_high) begin
            d = m_high - (n - m_lastf);
            if (d < 0) d = -d;
            bad = d > DTOL;
        end
`else
        d = 0;
`endif
        if (lev) begin
            m_meas = 0; m_cnt = 0; m_good = 0; e_fok = 0;
            m_seen = 0; m_have_high = 0; m_winbad = 0; e_duty = 0;
        end else begin
            if (m_meas && n == m_start + W) begin
                d = m_cnt - EXP;
                if (d < 0) d = -d;
                e_mv = 1;
                e_mc = 16'(m_cnt);
                e_fok = d <= TOL;
                m_good = !e_fok ? 0 : (m_good < LOCKN ? m_good + 1 : m_good);
                m_start = n;
                m_cnt = r ? 1 : 0;
`ifdef CLKDIV_DUTY_MON_EN
                e_duty = m_winbad | bad;
                m_winbad = 0;
`endif
            end else begin
                if (m_meas) begin
                    if (r) m_cnt++;
                end else if (r) begin
                    m_meas = 1; m_start = n; m_cnt = 1;
                end
`ifdef CLKDIV_DUTY_MON_EN
                if (bad) begin
                    e_duty = 1; m_winbad = 1;
                end
`endif
            end
            if (f) begin
                if (m_seen) begin
                    m_high = n - m_lastr; m_have_high = 1;
                end
                m_lastf = n;
            end
            if (r) begin
                m_seen = 1; m_have_high = 0; m_lastr = n;
            end
        end
        e_lock = (m_good == LOCKN);
    endtask

    function automatic logic [31:0] outs();
        return {9'b0, en_rise, en_fall, meas_valid, freq_ok, lock,
                clk_lost, duty_err, meas_count};
    endfunction

    task automatic tick(input logic v);
        @(posedge clk_src);
        n++;
        #1;
        clk_div = v;
        hist[n] = v;
        model_step();
        @(negedge clk_src);
        check($sformatf("outs@%0d", n), outs(),
              {9'b0, e_rise, e_fall, e_mv, e_fok, e_lock, e_lost, e_duty,
               e_mc});
        if (en_rise && first_rise < 0) begin
            first_rise = n;
            lost_at_fr = clk_lost;
        end
        if (en_fall && first_fall < 0) first_fall = n;
        if (en_rise || en_fall) last_obs = n;
        if (clk_lost && !lost_prev) lost_at = n;
        if (meas_valid) begin
            mv_seen++;
            if (mv_seen <= 2) mv_lock[mv_seen] = lock;
            if (first_mv < 0) first_mv = n;
            if (clk_lost) mv_lost++;
            if (!freq_ok && lock_prev && drop_seen == 0) begin
                drop_seen++;
                lock_at_drop = lock;
            end
        end
        lost_prev = clk_lost;
        lock_prev = lock;
    endtask

    task automatic clear_obs();
        lost_at = -1; first_rise = -1; first_fall = -1; first_mv = -1;
        mv_seen = 0; mv_lost = 0; drop_seen = 0;
        mv_lock[1] = 1'b1; mv_lock[2] = 1'b0;
    endtask

    task automatic run_wave(input int hi, input int lo, input int cyc,
                            input int ph0);
        for (int c = 0; c < cyc; c++) begin
            tick(((c + ph0) % (hi + lo)) < hi);
        end
    endtask

    task automatic hold_level(input logic v, input int cyc);
        for (int c = 0; c < cyc; c++) tick(v);
    endtask

    task automatic do_reset(input logic v0, input int hold);
        #2 reset_n = 1'b0;
        #1 check("rst_async", outs(), 32'h0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk_src);
            #1 clk_div = ((i / 20) % 2) != 0;
            @(negedge clk_src);
            check("rst_hold", outs(), 32'h0);
        end
        @(posedge clk_src);
        #1;
        reset_n = 1'b1;
        clk_div = v0;
        model_reset(v0);
        lost_prev = 0;
        lock_prev = 0;
        last_obs = 0;
    endtask

    task automatic random_segments(input int count);
        int mode, hi, lo;
        for (int s = 0; s < count; s++) begin
            mode = $urandom_range(0, 4);
            hi   = $urandom_range(15, 25);
            lo   = $urandom_range(15, 25);
            if (mode <= 2) begin
                run_wave(hi, lo, $urandom_range(800, 2500),
                         $urandom_range(0, hi + lo - 1));
            end else if (mode == 3) begin
                hold_level(1'($urandom_range(0, 1)),
                           $urandom_range(50, 400));
            end else begin
                for (int c = 0; c < 200; c++) begin
                    tick(1'($urandom_range(0, 1)));
                end
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        clear_obs();

        // reset with a toggling clk_div, released while clk_div=1
        do_reset(1'b1, 60);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1);
            check("arm_quiet", {30'b0, en_rise, en_fall}, 32'h0);
        end

        // nominal 20/20
        clear_obs();
        run_wave(20, 20, 3000, 0);
        check("nom_lock_w1", 32'(mv_lock[1]), 32'h0);
        check("nom_lock_w2", 32'(mv_lock[2]), 32'h1);
        check("nom_count", 32'(meas_count), 32'(EXP));
        check("nom_freq_ok", 32'(freq_ok), 32'h1);

        // off-frequency 18/18 after lock
        clear_obs();
        run_wave(18, 18, 2500, 0);
        check("off_count",
              32'((meas_count == 16'd27) || (meas_count == 16'd28)), 32'h1);
        check("off_freq_ok", 32'(freq_ok), 32'h0);
        check("off_lock_drop", {30'b0, drop_seen > 0, lock_at_drop},
              32'h2);

        // relock, then stop the clock
        run_wave(20, 20, 3500, 0);
        check("relock", 32'(lock), 32'h1);
        clear_obs();
        hold_level(1'b0, 600);
        check("lost_delay", 32'(lost_at - last_obs), 32'(LOST));
        check("lost_flag", 32'(clk_lost), 32'h1);
        check("lost_lock", 32'(lock), 32'h0);
        check("lost_no_mv", 32'(mv_lost), 32'h0);

        // resume: latency and first window after re-arm
        clear_obs();
        k = n + 1;
        run_wave(20, 20, 2500, 0);
        check("lat_rise", 32'(first_rise - k), 32'h3);
        check("lat_fall", 32'(first_fall - k), 32'd23);
        check("lost_clear", 32'(lost_at_fr), 32'h0);
        check("resume_mv", 32'(first_mv - first_rise), 32'(W));

        // duty imbalance then balanced duty
        run_wave(22, 18, 2200, 0);
`ifdef CLKDIV_DUTY_MON_EN
        check("duty_bad", 32'(duty_err), 32'h1);
`else
        check("duty_bad", 32'(duty_err), 32'h0);
`endif
        run_wave(21, 19, 2500, 0);
        check("duty_good", 32'(duty_err), 32'h0);

        random_segments(8);

        // reset mid-operation, then more random traffic
        do_reset(1'b0, 30);
        random_segments(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
